// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
// Shared constants and types for the LeNet-5 front-end datapath.
//   DATA_W      pixel width in bits
//   IMG_WIDTH   pixels per image row
//   IMG_HEIGHT  rows per frame
//   K           convolution window size (fixed at 5)
//   OUT_DIM     valid window positions per axis (IMG_WIDTH-K+1 = 28)
//   COORD_W     width of window coordinate outputs
//   X_CNT_W / Y_CNT_W  raster counter widths
// -----------------------------------------------------------------------------
package lenet_pkg;

   localparam int DATA_W     = 8;
   localparam int IMG_WIDTH  = 32;
   localparam int IMG_HEIGHT = 32;
   localparam int K          = 5;
   localparam int OUT_DIM    = IMG_WIDTH - K + 1;
   localparam int COORD_W    = 5;
   localparam int X_CNT_W    = $clog2(IMG_WIDTH);
   localparam int Y_CNT_W    = $clog2(IMG_HEIGHT);

   typedef logic [DATA_W-1:0] pix_t;

endpackage

// File: rtl/window_5x5_gen_raster_coord_cnt.sv
// -----------------------------------------------------------------------------
// raster_coord_cnt
// Raster-order x/y pixel counters with row and frame wrap.
// The counters hold the coordinates of the pixel that the next advance
// accepts; last_o flags that this pixel is the final one of the frame.
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   clear_i   synchronous restart to (0,0), priority over advance_i
//   advance_i accept the current pixel and step to the next position
//   x_o, y_o  coordinates of the current (not yet accepted) pixel
//   last_o    current pixel is (WIDTH-1, HEIGHT-1)
// -----------------------------------------------------------------------------
module raster_coord_cnt
   import lenet_pkg::*;
#(
   parameter int WIDTH  = IMG_WIDTH,
   parameter int HEIGHT = IMG_HEIGHT,
   parameter int XW     = X_CNT_W,
   parameter int YW     = Y_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          advance_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          last_o
);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          x_end, y_end;

   assign x_end = (x_q == XW'(WIDTH - 1));
   assign y_end = (y_q == YW'(HEIGHT - 1));

   // NOTE: every variable gets its default first so no path leaves it
   // unassigned; that is what keeps always_comb from inferring a latch.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear_i) begin
         x_d = '0;
         y_d = '0;
      end else if (advance_i) begin
         if (x_end) begin
            x_d = '0;
            y_d = y_end ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = x_end && y_end;

endmodule

// File: rtl/window_5x5_gen.sv
// -----------------------------------------------------------------------------
// window_5x5_gen
// Builds a sliding 5x5 pixel window from the 5-tap vertical column emitted by
// line_buffer_shift and presents it, with its top-left coordinates, to the C1
// convolution array. One window per valid position (28x28 per 32x32 frame).
//   clk, rst        clock / asynchronous active-high reset
//   clear           synchronous frame restart (counters, window_valid)
//   valid_in        one pulse per pixel, raster order
//   col_in0..4      rows y, y-1, y-2, y-3, y-4 of the current column
//   window_flat     element (r,c) at [(r*K+c)*DATA_W +: DATA_W], r=0 oldest row
//   window_valid    window_flat/out_x/out_y valid this cycle
//   out_x, out_y    window top-left coordinates, 0..27
//   frame_done      one-cycle pulse with the final window of the frame
// -----------------------------------------------------------------------------
module window_5x5_gen
   import lenet_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     valid_in,
   input  logic [DATA_W-1:0]        col_in0,
   input  logic [DATA_W-1:0]        col_in1,
   input  logic [DATA_W-1:0]        col_in2,
   input  logic [DATA_W-1:0]        col_in3,
   input  logic [DATA_W-1:0]        col_in4,
   output logic [K*K*DATA_W-1:0]    window_flat,
   output logic                     window_valid,
   output logic [COORD_W-1:0]       out_x,
   output logic [COORD_W-1:0]       out_y,
   output logic                     frame_done
);

   logic               accept;
   logic [X_CNT_W-1:0] x_cnt;
   logic [Y_CNT_W-1:0] y_cnt;
   logic               last_pix;
   logic               in_window;

   pix_t               col [K];
   pix_t               win_q [K][K];
   pix_t               win_d [K][K];
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic [COORD_W-1:0] out_x_q, out_x_d;
   logic [COORD_W-1:0] out_y_q, out_y_d;

   // A clear cycle drops the presented column entirely.
   assign accept = valid_in && !clear;

   raster_coord_cnt u_coord (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (clear),
      .advance_i (accept),
      .x_o       (x_cnt),
      .y_o       (y_cnt),
      .last_o    (last_pix)
   );

   // col[k] is row y-k; row r of the window receives col[K-1-r].
   assign col[0] = col_in0;
   assign col[1] = col_in1;
   assign col[2] = col_in2;
   assign col[3] = col_in3;
   assign col[4] = col_in4;

   // Positions with x<K-1 hold the previous row's tail and are suppressed.
   assign in_window = (x_cnt >= X_CNT_W'(K - 1)) && (y_cnt >= Y_CNT_W'(K - 1));

   always_comb begin
      win_d   = win_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      out_x_d = out_x_q;
      out_y_d = out_y_q;
      if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = col[K-1-r];
         end
         done_d = last_pix;
         if (in_window) begin
            valid_d = 1'b1;
            out_x_d = COORD_W'(x_cnt - X_CNT_W'(K - 1));
            out_y_d = COORD_W'(y_cnt - Y_CNT_W'(K - 1));
         end
      end
   end

   // NOTE: the window array is reset along with the control state so the
   // output bus reads zero after reset; it has no enable-free storage that
   // would prevent mapping it onto ordinary resettable flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         out_x_q <= '0;
         out_y_q <= '0;
      end else begin
         win_q   <= win_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         out_x_q <= out_x_d;
         out_y_q <= out_y_d;
      end
   end

   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         assign window_flat[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
      end
   end

   assign window_valid = valid_q;
   assign frame_done   = done_q;
   assign out_x        = out_x_q;
   assign out_y        = out_y_q;

endmodule

// File: tb/tb_window_5x5_gen.sv
// -----------------------------------------------------------------------------
// tb_window_5x5_gen
// Directed bench for window_5x5_gen: ramp frames through a line-buffer model,
// gapped input, back-to-back frames, mid-frame reset and clear.
// -----------------------------------------------------------------------------
module tb_window_5x5_gen;
   import lenet_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  clear = 1'b0;
   logic                  valid_in = 1'b0;
   logic [7:0]            col_in0 = '0, col_in1 = '0, col_in2 = '0, col_in3 = '0, col_in4 = '0;
   logic [199:0]          window_flat;
   logic                  window_valid;
   logic [4:0]            out_x, out_y;
   logic                  frame_done;

   int errors = 0;
   int checks = 0;
   int win_cnt = 0;
   int done_cnt = 0;

   window_5x5_gen dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .valid_in     (valid_in),
      .col_in0      (col_in0),
      .col_in1      (col_in1),
      .col_in2      (col_in2),
      .col_in3      (col_in3),
      .col_in4      (col_in4),
      .window_flat  (window_flat),
      .window_valid (window_valid),
      .out_x        (out_x),
      .out_y        (out_y),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int x, input int y);
      return 8'(x + 3 * y);
   endfunction

   function automatic logic [199:0] exp_win(input int x, input int y);
      logic [199:0] w;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            w[(r*5+c)*8 +: 8] = pix(x - 4 + c, y - 4 + r);
      return w;
   endfunction

   function automatic logic [7:0] elem(input int r, input int c);
      return window_flat[(r*5+c)*8 +: 8];
   endfunction

   // One accepted pixel, line-buffer column model (wraps to the previous
   // frame's rows for y<4), then all outputs checked #1 after the edge.
   task automatic drive_pixel(input int x, input int y);
      logic exp_v;
      col_in0  = pix(x, y);
      col_in1  = pix(x, (y + 31) % 32);
      col_in2  = pix(x, (y + 30) % 32);
      col_in3  = pix(x, (y + 29) % 32);
      col_in4  = pix(x, (y + 28) % 32);
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      exp_v = (x >= 4) && (y >= 4);
      check("window_valid", window_valid, exp_v);
      check("frame_done", frame_done, (x == 31) && (y == 31));
      if (frame_done) done_cnt++;
      if (exp_v) begin
         win_cnt++;
         check("window", {out_x, out_y, window_flat}, {5'(x - 4), 5'(y - 4), exp_win(x, y)});
      end
      if (x == 4 && y == 4) begin
         check("first_out", {out_x, out_y}, 10'd0);
         check("first_e00", elem(0, 0), 8'h00);
         check("first_e44", elem(4, 4), 8'h10);
      end
      if (x == 31 && y == 4) check("row_end_out", {out_x, out_y}, {5'd27, 5'd0});
      if (x == 4 && y == 5) begin
         check("row5_out", {out_x, out_y}, {5'd0, 5'd1});
         check("row5_e00", elem(0, 0), 8'h03);
      end
      if (x == 31 && y == 31) begin
         check("last_out", {out_x, out_y}, {5'd27, 5'd27});
         check("last_e44", elem(4, 4), 8'h7C);
      end
   endtask

   task automatic idle_cycle();
      valid_in = 1'b0;
      col_in0  = 8'($urandom);
      @(posedge clk);
      #1;
      check("gap_valid", window_valid, 1'b0);
      check("gap_done", frame_done, 1'b0);
   endtask

   task automatic run_frame(input int gap_pct);
      win_cnt  = 0;
      done_cnt = 0;
      for (int y = 0; y < 32; y++) begin
         for (int x = 0; x < 32; x++) begin
            for (int g = 0; g < 8 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++)
               idle_cycle();
            drive_pixel(x, y);
         end
      end
      check("win_count", win_cnt, 784);
      check("done_count", done_cnt, 1);
   endtask

   task automatic run_partial(input int n);
      for (int i = 0; i < n; i++) drive_pixel(i % 32, i / 32);
   endtask

   initial begin
      // Reset held with valid_in toggling.
      for (int i = 0; i < 4; i++) begin
         valid_in = i[0];
         col_in0  = 8'($urandom);
         col_in4  = 8'($urandom);
         @(posedge clk);
         #1;
         check("rst_valid", window_valid, 1'b0);
         check("rst_done", frame_done, 1'b0);
         check("rst_out", {out_x, out_y}, 10'd0);
         check("rst_window", window_flat, 200'd0);
      end
      valid_in = 1'b0;
      rst = 1'b0;

      run_frame(0);              // gap-free golden frame
      run_frame(0);              // back-to-back second frame
      run_frame(30);             // gapped input

      // Reset after pixel 500 (20,15), whose window is being shown.
      run_partial(501);
      check("pre_rst_valid", window_valid, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", window_valid, 1'b0);
      check("async_rst_window", window_flat, 200'd0);
      check("async_rst_out", {out_x, out_y}, 10'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_frame(0);

      // Clear after pixel 300 (12,9): presented column is dropped.
      run_partial(301);
      clear    = 1'b1;
      valid_in = 1'b1;
      col_in0  = 8'hEE;
      col_in1  = 8'hEE;
      col_in2  = 8'hEE;
      col_in3  = 8'hEE;
      col_in4  = 8'hEE;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      valid_in = 1'b0;
      check("clear_valid", window_valid, 1'b0);
      check("clear_done", frame_done, 1'b0);
      check("clear_window_hold", window_flat, exp_win(12, 9));
      check("clear_out_hold", {out_x, out_y}, {5'd8, 5'd5});
      run_frame(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
